// File: rtl/channel_ctrl.sv
// Per-channel sequencer for one analog channel: arms on a hit, times CSA sample/hold,
// drives the SAR ADC, hands the word downstream over valid/ready, and resets the CSA.
module channel_ctrl #(
    parameter int ADCBITS           = 10,
    parameter int SAMPLE_DELAY      = 2,
    parameter int SAMPLE_CYCLES     = 2,
    parameter int CONV_TIMEOUT      = 32,
    parameter int RESET_CYCLES      = 4,
    parameter int RESET_PERIOD_BITS = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         external_trigger,
    input  logic [RESET_PERIOD_BITS-1:0] periodic_reset_cycles,
    input  logic                         hit,
    input  logic                         done,
    input  logic [ADCBITS-1:0]           dout,
    output logic                         csa_reset,
    output logic                         sample,
    output logic                         strobe,
    output logic [ADCBITS-1:0]           event_data,
    output logic                         event_timeout,
    output logic                         event_valid,
    input  logic                         event_ready,
    output logic                         busy
);

    localparam int MAX_A   = (SAMPLE_DELAY > SAMPLE_CYCLES) ? SAMPLE_DELAY : SAMPLE_CYCLES;
    localparam int MAX_B   = (CONV_TIMEOUT > RESET_CYCLES) ? CONV_TIMEOUT : RESET_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_SAMPLE,
        ST_CONVERT,
        ST_OUTPUT,
        ST_RESET_CSA
    } state_t;

    state_t                         state_reg, state_next;
    logic [CW-1:0]                  cnt_reg, cnt_next;
    logic [RESET_PERIOD_BITS-1:0]   idle_cnt_reg;
    logic [1:0]                     async_in;
    logic [1:0]                     meta_reg;
    logic [1:0]                     sync_reg;
    logic                           hit_s;
    logic                           done_s;
    logic                           capture;
    logic                           time_out;

    logic                           csa_reset_reg;
    logic                           sample_reg;
    logic                           strobe_reg;
    logic [ADCBITS-1:0]             event_data_reg;
    logic                           event_timeout_reg;
    logic                           event_valid_reg;
    logic                           busy_reg;

    // Two-flop synchronizers: bit 0 = hit, bit 1 = done
    assign async_in = {done, hit};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_reg[gi] <= 1'b0;
                    sync_reg[gi] <= 1'b0;
                end else begin
                    meta_reg[gi] <= async_in[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign hit_s  = sync_reg[0];
    assign done_s = sync_reg[1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        time_out   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                // A trigger in the same cycle as periodic expiry wins
                if (enable && (hit_s || external_trigger)) begin
                    state_next = ST_HOLD;
                    cnt_next   = CW'(SAMPLE_DELAY - 1);
                end else if ((periodic_reset_cycles != '0) &&
                             (idle_cnt_reg >= periodic_reset_cycles - 1'b1)) begin
                    state_next = ST_RESET_CSA;
                    cnt_next   = CW'(RESET_CYCLES - 1);
                end
            end
            ST_HOLD: begin
                if (cnt_reg == '0) begin
                    state_next = ST_SAMPLE;
                    cnt_next   = CW'(SAMPLE_CYCLES - 1);
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (cnt_reg == '0) begin
                    state_next = ST_CONVERT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_CONVERT: begin
                // cnt_reg counts cycles since strobe; done on the strobe cycle is stale
                if ((cnt_reg != '0) && done_s) begin
                    capture    = 1'b1;
                    state_next = ST_OUTPUT;
                end else if (cnt_reg == CW'(CONV_TIMEOUT - 1)) begin
                    time_out   = 1'b1;
                    state_next = ST_OUTPUT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (event_ready) begin
                    state_next = ST_RESET_CSA;
                    cnt_next   = CW'(RESET_CYCLES - 1);
                end
            end
            ST_RESET_CSA: begin
                if (cnt_reg == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_RESET_CSA;
                cnt_next   = CW'(RESET_CYCLES - 1);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_RESET_CSA;
            cnt_reg           <= CW'(RESET_CYCLES - 1);
            idle_cnt_reg      <= '0;
            csa_reset_reg     <= 1'b1;
            sample_reg        <= 1'b0;
            strobe_reg        <= 1'b0;
            event_data_reg    <= '0;
            event_timeout_reg <= 1'b0;
            event_valid_reg   <= 1'b0;
            busy_reg          <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if ((state_reg == ST_IDLE) && (state_next == ST_IDLE)) begin
                if (idle_cnt_reg != '1) begin
                    idle_cnt_reg <= idle_cnt_reg + 1'b1;
                end
            end else begin
                idle_cnt_reg <= '0;
            end
            // Outputs are registered copies of the upcoming state
            csa_reset_reg   <= (state_next == ST_RESET_CSA);
            sample_reg      <= (state_next == ST_SAMPLE);
            strobe_reg      <= (state_reg != ST_CONVERT) && (state_next == ST_CONVERT);
            event_valid_reg <= (state_next == ST_OUTPUT);
            busy_reg        <= (state_next != ST_IDLE);
            if (capture) begin
                event_data_reg    <= dout;
                event_timeout_reg <= 1'b0;
            end else if (time_out) begin
                event_data_reg    <= '0;
                event_timeout_reg <= 1'b1;
            end
        end
    end

    assign csa_reset     = csa_reset_reg;
    assign sample        = sample_reg;
    assign strobe        = strobe_reg;
    assign event_data    = event_data_reg;
    assign event_timeout = event_timeout_reg;
    assign event_valid   = event_valid_reg;
    assign busy          = busy_reg;

endmodule

// File: doc/channel_ctrl.md
Name: channel_ctrl

Overview:
- Per-channel digital sequencer for the LArPix-v2 analog channel (CSA, discriminator, async SAR ADC).
- Arms the channel, detects discriminator hits, times the CSA sample/hold, launches and monitors the ADC conversion, and hands the digitized word to the channel FIFO over a valid/ready handshake.
- Resets the CSA after every event and periodically while idle.
- Sits between the analog channel model and the digital event builder; one instance per channel.

Parameters:
- ADCBITS, 10, ADC word width.
- SAMPLE_DELAY, 2, clk cycles from synchronized hit to sample assertion (peaking wait).
- SAMPLE_CYCLES, 2, cycles sample held high (track phase).
- CONV_TIMEOUT, 32, max cycles waiting for done after strobe.
- RESET_CYCLES, 4, cycles csa_reset held high per reset.
- RESET_PERIOD_BITS, 16, width of periodic-reset counter/config.

Ports:
- clk  input  1  master clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  channel enable; 0 forces IDLE behaviour with no new triggers
- external_trigger  input  1  forces an event as if hit (single-cycle pulse, already synchronous)
- periodic_reset_cycles  input  RESET_PERIOD_BITS  idle cycles between periodic CSA resets; 0 disables
- hit  input  1  discriminator output (asynchronous)
- done  input  1  ADC conversion complete (asynchronous, level)
- dout  input  ADCBITS  ADC result, valid while done=1
- csa_reset  output  1  CSA reset to analog channel
- sample  output  1  ADC sample (track) control
- strobe  output  1  ADC conversion start pulse
- event_data  output  ADCBITS  captured ADC word
- event_timeout  output  1  qualifies event_data: conversion timed out, data forced to 0
- event_valid  output  1  event available
- event_ready  input  1  downstream accepts event
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state=RESET_CSA with RESET_CYCLES count loaded; csa_reset=1; sample, strobe, event_valid, event_timeout, busy all 0 except busy=1; event_data=0; periodic counter=0; synchronizers cleared.
- hit and done each pass through a 2-flop synchronizer; "hit_s"/"done_s" denote the synchronized versions. hit-to-FSM latency is 2 cycles.
- States:
  - IDLE: csa_reset=0, busy=0. Transitions to HOLD with delay counter=SAMPLE_DELAY if enable & (hit_s | external_trigger); trigger has priority over periodic reset in the same cycle. Otherwise, if periodic_reset_cycles!=0 and the idle counter reaches periodic_reset_cycles-1, go to RESET_CSA. The idle counter increments each IDLE cycle, clears on leaving IDLE, and saturates (never wraps).
  - HOLD: count down; at 0, go to SAMPLE.
  - SAMPLE: sample=1 for exactly SAMPLE_CYCLES cycles, then go to CONVERT.
  - CONVERT: strobe=1 for the first cycle only, sample=0. Wait for done_s=1, then capture dout into event_data, set event_timeout=0, and go to OUTPUT. If CONV_TIMEOUT cycles elapse without done_s, set event_data=0 and event_timeout=1, then go to OUTPUT.
  - OUTPUT: event_valid=1. Data is stable until event_valid & event_ready, then go to RESET_CSA. event_valid drops the cycle after the handshake.
  - RESET_CSA: csa_reset=1 for RESET_CYCLES cycles, then go to IDLE.
- Hits arriving in any non-IDLE state are ignored (not queued). hit_s still high on return to IDLE retriggers.
- enable=0: no new triggers from IDLE; an in-progress event completes normally.
- done_s sampled in the cycle strobe is asserted is ignored (stale done from the previous conversion); capture requires done_s=1 on a cycle >=1 after strobe.
- reset asserted mid-operation: immediate return to reset state next edge; a pending event is discarded and event_valid is 0.
- Outputs are registered (no combinational paths from inputs to outputs).
- Timing: hit edge to strobe = 2 + 1 + SAMPLE_DELAY + SAMPLE_CYCLES cycles.

Test Plan:
- Reset release: reset high 3 cycles then low -> csa_reset=1 for 4 cycles post-reset, then IDLE, busy=0, event_valid=0.
- Single hit, dout=10'h2A5, done asserted 5 cycles after strobe, event_ready=1 -> strobe exactly 7 cycles after hit edge. Then event_data=10'h2A5, event_timeout=0, one-cycle valid, followed by 4 cycles of csa_reset.
- Backpressure: event_ready=0 for 10 cycles -> event_valid and event_data held stable for 10 cycles. Extra hits during this time are ignored; the event is accepted on the first ready cycle.
- Timeout: done never asserted -> 32 cycles after strobe, event_valid=1 with event_data=0 and event_timeout=1.
- Periodic reset: periodic_reset_cycles=100, no hits -> csa_reset pulses of 4 cycles every 100 idle cycles. Setting periodic_reset_cycles=0 stops them. A hit on the expiry cycle takes priority (goes to HOLD).
- Reset mid-CONVERT and enable=0: reset during CONVERT -> no event_valid, and csa_reset restarts. With enable=0, a hit yields no strobe; external_trigger is likewise ignored.
